axi_rr_burst_arbiter: RTL and testbench
=======================================

Name: axi_rr_burst_arbiter

Overview:
- N-to-1 burst arbiter for the AXI4 crossbar. It selects one of NUM requesting channels (e.g. W or R data streams) and holds that grant for the whole burst, until the beat carrying last handshakes.
- It emits a registered one-hot grant mask. The mask gates each source's payload, and the gated payloads are OR-merged onto a single output channel.
- It is the decision side of the one-hot merge: it produces the mask that the OR-reduction consumes, and it returns ready to exactly one source.

Parameters:
- NUM, 2, number of requesting channels (>=2).
- WIDTH, 64, payload width per channel (excluding valid/ready/last).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- src_valid  input  [NUM-1:0]  per-source valid.
- src_last  input  [NUM-1:0]  per-source last-beat flag.
- src_data  input  [WIDTH-1:0] x [0:NUM-1]  per-source payload, unpacked array.
- src_ready  output  [NUM-1:0]  per-source ready; only the granted bit may be 1.
- dst_valid  output  1  merged valid.
- dst_last  output  1  merged last.
- dst_data  output  [WIDTH-1:0]  merged payload.
- dst_ready  input  1  downstream ready.
- grant  output  [NUM-1:0]  registered one-hot grant mask; all-zero when idle.

Behaviour:
- States: IDLE, LOCKED. Reset state is IDLE.
- Reset values: grant=0, rr_ptr=0, state=IDLE. All combinational outputs (src_ready, dst_valid, dst_last) therefore read 0, and dst_data reads 0.
- IDLE:
  - If any src_valid is set, choose the first set bit scanning from rr_ptr upward, wrapping modulo NUM.
  - Load grant with that one-hot value and go to LOCKED next cycle.
  - Outputs stay deasserted in the arbitration cycle. This gives a fixed one-cycle bubble per burst.
- LOCKED:
  - dst_valid = |(src_valid & grant), dst_last = |(src_last & grant).
  - dst_data = OR over i of (src_data[i] masked by grant[i]).
  - src_ready = grant & {NUM{dst_ready}}.
  - Fully combinational in LOCKED, zero added latency per beat.
- Release:
  - Occurs on dst_valid & dst_ready & dst_last in LOCKED.
  - Next cycle: grant=0, state=IDLE, rr_ptr=(granted index+1) mod NUM.
  - Back-to-back bursts therefore cost exactly one idle cycle between them.
- Grant stays locked across non-last handshakes and across cycles where the granted source drops valid (mid-burst stall). Other sources' valids are ignored while locked.
- Single-beat burst (last on first beat) is legal: LOCKED lasts exactly one cycle if dst_ready=1.
- Fairness: a continuously requesting source waits at most NUM-1 bursts.
- Index wrap: NUM not a power of two must wrap correctly (e.g. NUM=3, granted 2 gives rr_ptr=0).
- Asynchronous reset mid-burst drops grant immediately. No beat handshakes while rst_n=0.
- Invariant: grant is one-hot or zero at all times. src_ready & ~grant == 0 always.

Decomposition:
- Shared crossbar package holds:
  - localparam function for the index width, clog2(NUM) with minimum 1.
  - enum typedef arb_state_e {ARB_IDLE, ARB_LOCKED}.
- One natural sub-module: onehot_or_merge (NUM, WIDTH).
  - Masks the unpacked src_data by grant and OR-reduces it through a prefix-OR chain.
  - Reused for the data, last and valid merges.
- The round-robin pick stays inline: a double-width rotate plus priority encoder.

Test Plan:
- Reset: hold rst_n=0 with src_valid=2'b11 -> grant=0, src_ready=0, dst_valid=0. After release, one arbitration cycle, then grant=2'b01 (rr_ptr=0).
- Alternation, NUM=2: both sources stream 4-beat bursts with dst_ready=1 -> grant sequence 01,10,01,10. One idle cycle between bursts. dst_data matches each source's beats in order.
- Lock under stall: source0 burst of 3 beats, dst_ready toggling 1,0,1,0,1, source1 valid throughout -> grant stays 01 until beat 3 handshakes. src_ready[1] is never 1 during that window.
- Single beat with wrap, NUM=3: only source2 valid with last=1, payload 64'hA5A5 -> dst_data=64'hA5A5 for one cycle. After release rr_ptr=0, and next requester source1 wins over nothing before it.
- Valid gap mid-burst: granted source deasserts valid for 2 cycles between beats 1 and 2 -> dst_valid=0 those cycles, grant unchanged, burst completes on its own last.
- Async reset mid-burst: assert rst_n=0 between clock edges after beat 2 of 4 -> grant, src_ready and dst_valid go to 0 without waiting for an edge. After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/axi_rr_burst_arbiter_pkg.sv
// axi_rr_burst_arbiter_pkg: shared crossbar types and index sizing for the burst arbiter.
package axi_rr_burst_arbiter_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  function automatic int idx_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_rr_burst_arbiter_onehot_or_merge.sv
// axi_rr_burst_arbiter_onehot_or_merge: masks each input by its one-hot select bit and OR-reduces them.
module axi_rr_burst_arbiter_onehot_or_merge #(
  parameter int NUM   = 2,
  parameter int WIDTH = 64
) (
  input  logic [NUM-1:0]   sel,
  input  logic [WIDTH-1:0] din [NUM],
  output logic [WIDTH-1:0] dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM; i++) dout = dout | (din[i] & {WIDTH{sel[i]}});
  end
endmodule

// File: rtl/axi_rr_burst_arbiter.sv
// axi_rr_burst_arbiter: round-robin N-to-1 arbiter that locks a registered one-hot grant for a whole burst.
module axi_rr_burst_arbiter
  import axi_rr_burst_arbiter_pkg::*;
#(
  parameter int NUM   = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM-1:0]   src_valid,
  input  logic [NUM-1:0]   src_last,
  input  logic [WIDTH-1:0] src_data [NUM],
  output logic [NUM-1:0]   src_ready,
  output logic             dst_valid,
  output logic             dst_last,
  output logic [WIDTH-1:0] dst_data,
  input  logic             dst_ready,
  output logic [NUM-1:0]   grant
);
  localparam int IW = idx_w(NUM);
  arb_state_e state;
  logic [IW-1:0] rr_ptr, gidx, pick, off;
  logic [IW:0] sum;
  logic [NUM-1:0] rot;
  logic [0:0] valid_v [NUM];
  logic [0:0] last_v [NUM];
  always_comb begin
    rot = NUM'({src_valid, src_valid} >> rr_ptr);
    off = '0;
    for (int i = NUM - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
    sum = {1'b0, rr_ptr} + {1'b0, off};
    pick = sum >= (IW+1)'(NUM) ? IW'(sum - (IW+1)'(NUM)) : IW'(sum);
  end
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      valid_v[i] = src_valid[i];
      last_v[i]  = src_last[i];
    end
  end
  axi_rr_burst_arbiter_onehot_or_merge #(.NUM(NUM), .WIDTH(WIDTH)) u_data (
    .sel(grant), .din(src_data), .dout(dst_data));
  axi_rr_burst_arbiter_onehot_or_merge #(.NUM(NUM), .WIDTH(1)) u_valid (
    .sel(grant), .din(valid_v), .dout(dst_valid));
  axi_rr_burst_arbiter_onehot_or_merge #(.NUM(NUM), .WIDTH(1)) u_last (
    .sel(grant), .din(last_v), .dout(dst_last));
  assign src_ready = grant & {NUM{dst_ready}};
  // grant is zero whenever IDLE, so the merges alone keep outputs quiet during arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      gidx   <= '0;
    end else if (state == ARB_IDLE) begin
      if (|src_valid) begin
        state <= ARB_LOCKED;
        grant <= NUM'(1) << pick;
        gidx  <= pick;
      end
    end else if (dst_valid && dst_ready && dst_last) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= (gidx == IW'(NUM - 1)) ? '0 : gidx + IW'(1);
    end
  end
endmodule

// File: tb/tb_axi_rr_burst_arbiter.sv
// tb_axi_rr_burst_arbiter: randomized scoreboard bench with a burst-level round-robin reference model.
module tb_axi_rr_burst_arbiter;
  localparam int NUM = 3, WIDTH = 64;
  typedef struct packed {logic last; logic [WIDTH-1:0] data;} beat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NUM-1:0] src_valid = '0, src_last = '0, src_ready, grant;
  logic [WIDTH-1:0] src_data [NUM];
  logic dst_valid, dst_last, dst_ready = 1'b0;
  logic [WIDTH-1:0] dst_data;
  always #5 clk = ~clk;
  axi_rr_burst_arbiter #(.NUM(NUM), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_last(src_last), .src_data(src_data),
    .src_ready(src_ready), .dst_valid(dst_valid), .dst_last(dst_last), .dst_data(dst_data),
    .dst_ready(dst_ready), .grant(grant));
  beat_t src_q [NUM][$];
  beat_t exp_q [$];
  int checks = 0, passes = 0;
  int m_owner = -1, m_ptr = 0, gap_pct = 0, rdy_pct = 100;
  logic [NUM-1:0] s_ready = '0, eg;
  beat_t b;
  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  // monitor: compares mid-cycle outputs against the model and drains the scoreboard on handshakes
  always @(negedge clk) begin
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("grant", grant, eg);
    chk("src_ready", src_ready, eg & {NUM{dst_ready}});
    chk("dst_valid", dst_valid, (m_owner >= 0) ? src_valid[m_owner] : 1'b0);
    if (dst_valid && dst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat: got %h expected none at %0t", dst_data, $time);
      end else begin
        b = exp_q.pop_front();
        chk("dst_data", dst_data, b.data);
        chk("dst_last", dst_last, b.last);
      end
    end
    s_ready = src_ready;
  end
  task automatic load(input int s, input int n);
    for (int j = 0; j < n; j++) src_q[s].push_back({j == n - 1, WIDTH'({$urandom, $urandom})});
  endtask
  task automatic grant_to(input int c);
    int k;
    m_owner = c;
    k = 0;
    while (k < src_q[c].size()) begin
      exp_q.push_back(src_q[c][k]);
      if (src_q[c][k].last) break;
      k++;
    end
  endtask
  task automatic step();
    bit found;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (m_owner < 0) begin
        found = 0;
        for (int k = 0; k < NUM; k++)
          if (!found && src_valid[(m_ptr + k) % NUM]) begin
            found = 1;
            grant_to((m_ptr + k) % NUM);
          end
      end else if (src_valid[m_owner] && dst_ready && src_last[m_owner]) begin
        m_ptr = (m_owner + 1) % NUM;
        m_owner = -1;
      end
      for (int i = 0; i < NUM; i++)
        if (src_valid[i] && s_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    for (int i = 0; i < NUM; i++) begin
      if (src_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
        src_valid[i] = 1'b1;
        src_last[i] = src_q[i][0].last;
        src_data[i] = src_q[i][0].data;
      end else begin
        src_valid[i] = 1'b0;
        src_last[i] = 1'($urandom);
        src_data[i] = WIDTH'({$urandom, $urandom});
      end
    end
    dst_ready = $urandom_range(99) < rdy_pct;
  endtask
  function automatic bit idle();
    idle = m_owner < 0;
    for (int i = 0; i < NUM; i++) if (src_q[i].size() > 0) idle = 0;
  endfunction
  task automatic run_phase(input string nm, input int gp, input int rp, input int budget);
    gap_pct = gp;
    rdy_pct = rp;
    for (int n = 0; n < budget && !idle(); n++) step();
    checks++;
    if (idle()) passes++;
    else $display("FAIL %s_timeout: got busy expected idle after %0d cycles", nm, budget);
  endtask
  task automatic async_reset(input int hold);
    #2 rst_n = 1'b0;
    m_owner = -1;
    m_ptr = 0;
    exp_q.delete();
    #1;
    chk("rst_grant", grant, '0);
    chk("rst_src_ready", src_ready, '0);
    chk("rst_dst_valid", dst_valid, '0);
    repeat (hold) step();
    #2 rst_n = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < NUM; i++) src_data[i] = '0;
    for (int i = 0; i < NUM; i++) load(i, 4);
    gap_pct = 0;
    rdy_pct = 100;
    repeat (3) step();
    #2 rst_n = 1'b1;
    run_phase("alternate", 0, 100, 200);
    load(0, 3);
    load(1, 2);
    run_phase("stall", 0, 50, 200);
    src_q[2].push_back({1'b1, WIDTH'(64'hA5A5)});
    run_phase("single_wrap", 0, 100, 50);
    load(1, 2);
    run_phase("after_wrap", 0, 100, 50);
    load(0, 4);
    load(2, 3);
    run_phase("gaps", 40, 100, 300);
    repeat (12) begin
      for (int i = 0; i < NUM; i++) if ($urandom_range(3) != 0) load(i, $urandom_range(1, 5));
      if ($urandom_range(1)) load($urandom_range(NUM - 1), 1);
      run_phase("random", 25, 70, 600);
    end
    load(1, 4);
    load(2, 4);
    gap_pct = 0;
    rdy_pct = 100;
    for (int n = 0; n < 20 && m_owner < 0; n++) step();
    step();
    step();
    chk("locked_before_rst", grant != '0, 1'b1);
    async_reset(2);
    run_phase("post_reset", 0, 100, 200);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
